piso_serial_tx: RTL and testbench

//  Parallel-in/serial-out transmitter: the sending end of the team's serial bit links.

---
 rtl/serial_pkg.sv | 18 +
 rtl/serial_bit_counter.sv | 29 ++
 rtl/piso_serial_tx.sv | 72 +++++++
 tb/tb_piso_serial_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial bit-link transmitter and receiver.
// Holds the FSM state encoding and a width helper for the bit counters.
package serial_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  // Bits needed to hold the values 0..v-1; at least 1 for v >= 2.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (((v - 1) >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Bit-position counter for a WIDTH-bit serial word: clr wins over en and
// counting holds at WIDTH-1; no internal latency, last decodes directly from cnt.
module serial_bit_counter
  import serial_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int CW = clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          last
);

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !last) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter: first bit on q the cycle after accept.
// din_ready only in IDLE or on a word's last bit, so back-to-back words have no gap.
module piso_serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             q,
  output logic             q_valid,
  output logic             q_first,
  output logic             busy,
  output logic             done
);

  localparam int CW = clog2(WIDTH);

  logic             state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    bit_cnt;
  logic             last;
  logic             in_shift;
  logic             accept;
  logic             head;

  assign in_shift  = (state == ST_SHIFT);
  assign din_ready = !in_shift || last;
  assign accept    = din_valid && din_ready;

  // The bit leaving next always sits at the output end; refill with zeros.
  assign shifted = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0}
                             : {1'b0, shift_reg[WIDTH-1:1]};
  assign head    = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];

  serial_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk (clk),
    .rst (rst),
    .clr (accept || (in_shift && last)),
    .en  (in_shift),
    .cnt (bit_cnt),
    .last(last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
    end else if (accept) begin
      state     <= ST_SHIFT;
      shift_reg <= din;
    end else if (in_shift) begin
      shift_reg <= shifted;
      if (last) state <= ST_IDLE;
    end
  end

  // Outputs decode from registered state only, so reset clears them at once.
  assign q_valid = in_shift;
  assign busy    = in_shift;
  assign q       = in_shift && head;
  assign q_first = in_shift && (bit_cnt == '0);
  assign done    = in_shift && last;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: stimulus pushes expected {q,q_first,done} per bit,
// a negedge monitor pops and compares whenever q_valid is high.
module tb_piso_serial_tx;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       q;
  logic       q_valid;
  logic       q_first;
  logic       busy;
  logic       done;

  logic [3:0] din_l;
  logic       din_valid_l;
  logic       din_ready_l;
  logic       q_l;
  logic       q_valid_l;
  logic       q_first_l;
  logic       busy_l;
  logic       done_l;

  int checks;
  int errors;
  logic [2:0] exp_q[$];

  piso_serial_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .q        (q),
    .q_valid  (q_valid),
    .q_first  (q_first),
    .busy     (busy),
    .done     (done)
  );

  piso_serial_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk      (clk),
    .rst      (rst),
    .din      (din_l),
    .din_valid(din_valid_l),
    .din_ready(din_ready_l),
    .q        (q_l),
    .q_valid  (q_valid_l),
    .q_first  (q_first_l),
    .busy     (busy_l),
    .done     (done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Presents d and waits for din_ready; on accept queues the four expected bits.
  task automatic send_word(input logic [3:0] d, output int waits);
    logic ok;
    logic [2:0] e;
    ok = 1'b0;
    waits = 0;
    @(negedge clk);
    #1;
    din = d;
    din_valid = 1'b1;
    while (!ok && waits < 20) begin
      if (din_ready) begin
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
          e = {d[3-i], (i == 0), (i == 3)};
          exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
      end else begin
        waits++;
        @(negedge clk);
        #1;
      end
    end
    if (!ok) chk("send_ready_timeout", {31'd0, din_ready}, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  always @(negedge clk) begin
    logic [2:0] e;
    if (!rst) begin
      chk("busy_eq_q_valid", {31'd0, busy}, {31'd0, q_valid});
      if (q_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_q_valid", {31'd0, q_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("q", {31'd0, q}, {31'd0, e[2]});
          chk("q_first", {31'd0, q_first}, {31'd0, e[1]});
          chk("done", {31'd0, done}, {31'd0, e[0]});
        end
      end else begin
        chk("idle_q", {31'd0, q}, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);
        if (exp_q.size() != 0) chk("gap_q_valid", {31'd0, q_valid}, 32'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [3:0] lsb_q;
    logic [3:0] lsb_first;
    logic [3:0] lsb_done;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    din = 4'hF;
    din_valid = 1'b1;
    din_l = 4'h0;
    din_valid_l = 1'b0;

    // 1. Reset held with a pending word.
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_q", {31'd0, q}, 32'd0);
      chk("rst_q_valid", {31'd0, q_valid}, 32'd0);
      chk("rst_q_first", {31'd0, q_first}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_din_ready", {31'd0, din_ready}, 32'd1);
    end
    din_valid = 1'b0;
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("no_accept_in_reset", {31'd0, q_valid}, 32'd0);

    // 2. Single word.
    send_word(4'b1010, w);
    din_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("single_ready_c3", {31'd0, din_ready}, 32'd0);
    @(negedge clk);
    #1;
    chk("single_ready_c4", {31'd0, din_ready}, 32'd1);
    @(negedge clk);
    #1;
    chk("single_q_valid_c5", {31'd0, q_valid}, 32'd0);
    drain();

    // 3. Back to back.
    send_word(4'b1010, w);
    send_word(4'b0111, w);
    chk("b2b_wait_cycles", w, 32'd3);
    din_valid = 1'b0;
    drain();

    // 4. Busy: a new word offered during a transmission waits for the last bit.
    send_word(4'b1000, w);
    send_word(4'b1111, w);
    chk("busy_wait_cycles", w, 32'd3);
    din_valid = 1'b0;
    drain();

    // 5. Reset mid-word.
    send_word(4'b1100, w);
    din_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_q", {31'd0, q}, 32'd0);
    chk("midrst_q_valid", {31'd0, q_valid}, 32'd0);
    chk("midrst_din_ready", {31'd0, din_ready}, 32'd1);
    exp_q.delete();
    #1;
    rst = 1'b0;
    send_word(4'b0011, w);
    din_valid = 1'b0;
    drain();

    // 6. LSB-first instance.
    lsb_q = 4'b0001;
    lsb_first = 4'b0001;
    lsb_done = 4'b1000;
    @(negedge clk);
    #1;
    din_l = 4'b0001;
    din_valid_l = 1'b1;
    chk("lsb_ready", {31'd0, din_ready_l}, 32'd1);
    @(posedge clk);
    #1;
    din_valid_l = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("lsb_q_valid", {31'd0, q_valid_l}, 32'd1);
      chk("lsb_q", {31'd0, q_l}, {31'd0, lsb_q[i]});
      chk("lsb_q_first", {31'd0, q_first_l}, {31'd0, lsb_first[i]});
      chk("lsb_done", {31'd0, done_l}, {31'd0, lsb_done[i]});
    end
    @(negedge clk);
    #1;
    chk("lsb_idle_q_valid", {31'd0, q_valid_l}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
